// File: rtl/prio_grant_arbiter_if.sv
// Request/grant bundle between requesters and prio_grant_arbiter.
//   req       requester -> arbiter, one bit per requester, held while ownership is wanted
//   gnt       arbiter -> requesters, registered one-hot grant
//   gnt_valid arbiter -> requesters, high when gnt is nonzero
//   gnt_id    arbiter -> requesters, binary index of the owner (0 when idle)
//   preempt   arbiter -> requesters, one-cycle pulse when a hold-limit preemption lands
// master: requester side, slave: arbiter side.
interface prio_grant_arbiter_if #(
   parameter int unsigned N   = 3,
   parameter int unsigned IDW = 2
);
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic           preempt;

   modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
   modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/prio_grant_arbiter.sv
// Fixed-priority (highest index wins), non-preemptive-by-priority arbiter with a
// hold-time limit that forces re-arbitration when other requesters are waiting.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  prio_grant_arbiter_if.slave (req in; gnt, gnt_valid, gnt_id, preempt out)
// Optional build macro PRIO_ARB_STARVE_GUARD_EN adds per-requester wait counters;
// requesters waiting >= STARVE_LIMIT cycles take precedence at arbitration points.
// N and IDW must match the parameters of the connected interface instance.
module prio_grant_arbiter #(
   parameter int unsigned N            = 3,
   parameter int unsigned IDW          = 2,
   parameter int unsigned MAX_HOLD     = 8,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic                clk,
   input  logic                rst,
   prio_grant_arbiter_if.slave bus
);
   localparam int unsigned HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

   // Elaboration-time parameter sanity check
   if (N < 2 || N > 8 || (1 << IDW) < N || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
      $error("prio_grant_arbiter: illegal parameter combination");
   end

   typedef enum logic {IDLE, OWNED} state_t;

   state_t         state;
   logic [HCW-1:0] hold_cnt;
   logic [N-1:0]   gnt_q;
   logic           gnt_valid_q;
   logic [IDW-1:0] gnt_id_q;
   logic           preempt_q;

   logic [N-1:0]   req;
   logic [N-1:0]   others;
   logic [N-1:0]   starved;
   logic [N-1:0]   pick_all;
   logic [N-1:0]   pick_others;
   logic           owner_req;
   logic           hold_hit;

   // One-hot of the highest set bit
   function automatic logic [N-1:0] sel(input logic [N-1:0] v);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) r = N'(1) << i;
      end
      return r;
   endfunction

   // Binary index of a one-hot vector (0 for all-zero)
   function automatic logic [IDW-1:0] idx(input logic [N-1:0] v);
      logic [IDW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) r = IDW'(i);
      end
      return r;
   endfunction

   // Starved candidates take precedence; otherwise plain fixed priority
   function automatic logic [N-1:0] choose(input logic [N-1:0] cand, input logic [N-1:0] stv);
      return ((cand & stv) != '0) ? sel(cand & stv) : sel(cand);
   endfunction

   assign req       = bus.req;
   assign owner_req = |(req & gnt_q);
   assign others    = req & ~gnt_q;
   // >= rather than == so an owner whose counter saturated while alone is still
   // bounded once someone else starts waiting
   assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt >= HCW'(MAX_HOLD - 1)) && (others != '0);

   assign pick_all    = choose(req, starved);
   assign pick_others = choose(others, starved);

`ifdef PRIO_ARB_STARVE_GUARD_EN
   logic [7:0] wait_cnt [N];

   // Wait counters: count while requesting and not owning, clear otherwise
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst || !req[i] || gnt_q[i]) begin
            wait_cnt[i] <= 8'd0;
         end else if (wait_cnt[i] != 8'hFF) begin
            wait_cnt[i] <= wait_cnt[i] + 8'd1;
         end
      end
   end

   always_comb begin
      starved = '0;
      for (int i = 0; i < N; i++) begin
         starved[i] = (wait_cnt[i] >= 8'(STARVE_LIMIT));
      end
   end
`else
   assign starved = '0;
`endif

   // Arbitration FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         preempt_q   <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req != '0) begin
                  state       <= OWNED;
                  gnt_q       <= pick_all;
                  gnt_valid_q <= 1'b1;
                  gnt_id_q    <= idx(pick_all);
                  hold_cnt    <= '0;
               end
            end
            OWNED: begin
               if (!owner_req) begin
                  // Release wins over a coincident hold-limit hit
                  state       <= (req != '0) ? OWNED : IDLE;
                  gnt_q       <= pick_all;
                  gnt_valid_q <= |pick_all;
                  gnt_id_q    <= idx(pick_all);
                  hold_cnt    <= '0;
               end else if (hold_hit) begin
                  gnt_q       <= pick_others;
                  gnt_valid_q <= 1'b1;
                  gnt_id_q    <= idx(pick_others);
                  hold_cnt    <= '0;
                  preempt_q   <= 1'b1;
               end else if (hold_cnt != HCW'(MAX_HOLD)) begin
                  hold_cnt <= hold_cnt + HCW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Directed self-checking bench for prio_grant_arbiter (N=3, MAX_HOLD=4, STARVE_LIMIT=16).
// Each vector applies req/rst before a rising edge and checks the registered outputs
// 1 time unit after that edge.
module tb_prio_grant_arbiter;
   logic clk;
   logic rst;
   int   vectors;
   int   errors;

   prio_grant_arbiter_if #(.N(3), .IDW(2)) bus ();

   prio_grant_arbiter #(
      .N(3), .IDW(2), .MAX_HOLD(4), .STARVE_LIMIT(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] id_of(input logic [2:0] g);
      return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] rq [4] = '{3'b111, 3'b111, 3'b111, 3'b000};
      logic       rs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0] eg [4] = '{3'b000, 3'b000, 3'b100, 3'b000};
      logic [6:0] obs, exp;
      for (int i = 0; i < 4; i++) begin
         rst = rs[i]; bus.req = rq[i];
         tick();
         obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
         exp = {eg[i], |eg[i], id_of(eg[i]), 1'b0};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL reset[%0d] got %b want %b", i, obs, exp);
            errors++;
         end
      end
   endtask

   task automatic test_priority();
      logic [2:0] rq [7] = '{3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b000};
      logic [2:0] eg [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
      logic       ep [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [6:0] obs, exp;
      for (int i = 0; i < 7; i++) begin
         bus.req = rq[i];
         tick();
         obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
         exp = {eg[i], |eg[i], id_of(eg[i]), ep[i]};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL priority[%0d] got %b want %b", i, obs, exp);
            errors++;
         end
      end
   endtask

   task automatic test_release();
      logic [2:0] rq [5] = '{3'b010, 3'b111, 3'b101, 3'b101, 3'b000};
      logic [2:0] eg [5] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
      logic [6:0] obs, exp;
      for (int i = 0; i < 5; i++) begin
         bus.req = rq[i];
         tick();
         obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
         exp = {eg[i], |eg[i], id_of(eg[i]), 1'b0};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL release[%0d] got %b want %b", i, obs, exp);
            errors++;
         end
      end
   endtask

   task automatic test_hold_limit();
      logic [2:0] rq [10] = '{3'b001, 3'b101, 3'b101, 3'b101, 3'b101,
                              3'b101, 3'b101, 3'b101, 3'b101, 3'b000};
      logic [2:0] eg [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
                              3'b100, 3'b100, 3'b100, 3'b001, 3'b000};
      logic       ep [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [6:0] obs, exp;
      for (int i = 0; i < 10; i++) begin
         bus.req = rq[i];
         tick();
         obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
         exp = {eg[i], |eg[i], id_of(eg[i]), ep[i]};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL hold_limit[%0d] got %b want %b", i, obs, exp);
            errors++;
         end
      end
      // Lone owner keeps the grant indefinitely
      bus.req = 3'b001;
      for (int i = 0; i < 55; i++) begin
         tick();
         obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
         exp = {3'b001, 1'b1, 2'd0, 1'b0};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL hold_alone[%0d] got %b want %b", i, obs, exp);
            errors++;
         end
      end
      bus.req = 3'b000;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [2:0] rq [11] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b111, 3'b111,
                              3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
      logic       rs [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] eg [11] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b100,
                              3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
      logic       ep [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [6:0] obs, exp;
      for (int i = 0; i < 11; i++) begin
         rst = rs[i]; bus.req = rq[i];
         tick();
         obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
         exp = {eg[i], |eg[i], id_of(eg[i]), ep[i]};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL reset_mid[%0d] got %b want %b", i, obs, exp);
            errors++;
         end
      end
   endtask

   task automatic test_starvation();
      int first0;
      int npre;
      logic [6:0] obs, exp;
      first0 = 0;
      npre   = 0;
      bus.req = 3'b111;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (bus.gnt[0] && first0 == 0) first0 = c;
         if (bus.preempt) npre++;
      end
`ifdef PRIO_ARB_STARVE_GUARD_EN
      vectors++;
      if (first0 !== 17) begin
         $display("FAIL starve_first_grant got %0d want 17", first0);
         errors++;
      end
`else
      vectors++;
      if (first0 !== 0) begin
         $display("FAIL starve_never_grant0 got %0d want 0", first0);
         errors++;
      end
      vectors++;
      if (npre !== 9) begin
         $display("FAIL starve_preempt_count got %0d want 9", npre);
         errors++;
      end
`endif
      bus.req = 3'b000;
      tick();
      obs = {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt};
      exp = 7'b0;
      vectors++;
      if (obs !== exp) begin
         $display("FAIL starve_idle got %b want %b", obs, exp);
         errors++;
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      rst     = 1'b1;
      bus.req = 3'b000;
      test_reset();
      test_priority();
      test_release();
      test_hold_limit();
      test_reset_mid();
      test_starvation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/prio_grant_arbiter.md
Name: prio_grant_arbiter

Overview:
- Cycle-registered arbiter that shares one resource between N requesters.
- Priority is fixed, with the highest index winning. This is the same ordering the team's 3-input priority encoder uses: bit 2 has top priority, bit 0 has lowest.
- A grant is held until its requester releases it. A hold-time limit forces re-arbitration when others are waiting.
- Sits in front of any shared datapath resource (bus port, encoder-fed mux, memory port) and produces a one-hot grant and a binary grant index.

Parameters:
- N, 3: number of requesters (2..8).
- IDW, 2: width of gnt_id. Must be at least ceil(log2(N)).
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant while another request is pending. 0 disables the limit.
- STARVE_LIMIT, 16: wait-cycle threshold for the optional starvation guard (8-bit counter, 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector. A requester holds its bit high for as long as it wants ownership.
- gnt  output  N  registered one-hot grant. All zeros when no owner.
- gnt_valid  output  1  high when gnt is nonzero.
- gnt_id  output  IDW  binary index of the current owner. 0 when gnt_valid is 0.
- preempt  output  1  one-cycle pulse on the cycle a hold-limit preemption takes effect.

Behaviour:
- Reset: values taken at the clk edge with rst=1.
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - State IDLE, hold_cnt=0; starvation counters 0 when the optional feature is enabled.
  - rst has priority over everything. An active grant is dropped by the next edge.
- Selection function sel(v): one-hot of the highest set bit of v; 0 if v==0.
- States: IDLE and OWNED.
- IDLE:
  - req==0: stay in IDLE.
  - req!=0: next cycle gnt=sel(req) and state becomes OWNED. Latency is exactly 1 clock from req to gnt; hold_cnt resets to 0.
- OWNED, with owner k:
  - Release (req[k]==0): next cycle gnt=sel(req); no bubble when others are waiting. If req==0, go to IDLE with gnt=0. hold_cnt resets to 0.
  - Hold (req[k]==1, no preemption): gnt is unchanged and hold_cnt increments, saturating at MAX_HOLD.
  - Preemption: occurs when req[k]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0.
    - Next cycle gnt=sel(req & ~gnt), hold_cnt=0, preempt=1 for that one cycle.
    - The displaced requester re-competes normally.
  - No other requests pending: the owner keeps the grant indefinitely and hold_cnt saturates.
- Non-preemptive by priority: a higher-priority request arriving while another requester owns the grant waits for release or the hold limit.
- Simultaneous events:
  - Release and new requests in the same cycle are resolved by sel over the current req.
  - Release coinciding with a hold-limit hit counts as a release, so preempt stays 0.
- Output consistency: gnt_valid==|gnt and gnt_id==index(gnt) on every cycle.
- gnt never has more than one bit set.
- A requester is never granted in a cycle after the one in which its req bit was sampled low.

Optional Feature:
- Macro: PRIO_ARB_STARVE_GUARD_EN.
- Defined:
  - Each requester has an 8-bit wait counter. It increments, saturating, each cycle the requester's req=1 and it is not the owner, and clears when it is granted or when req drops.
  - At any arbitration point (IDLE grant, release, preemption), requesters whose counter is >= STARVE_LIMIT are "starved". If any are starved, the choice becomes sel(starved mask) instead of sel(req); the highest-index starved requester wins.
- Undefined: no counters; pure fixed priority as described above.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=3'b111 -> gnt=0, gnt_valid=0, gnt_id=0 during reset. First edge after rst drops -> gnt=3'b100, gnt_id=2.
- Priority and latency: from IDLE, req=3'b011 at cycle t -> gnt=3'b010 at t+1. At t+3 set req=3'b111 -> gnt stays 3'b010 (no preemption by priority).
- Release handoff: owner 1 with req=3'b101. Drop req[1] at cycle t -> gnt=3'b100 at t+1 with no idle cycle. Then drop all -> gnt=0, gnt_valid=0 next cycle.
- Hold limit: MAX_HOLD=4, req[0] held, req[2] raised one cycle after grant 0 -> grant 0 lasts 4 cycles, then gnt=3'b100 with preempt=1 for exactly one cycle. With req[2] never raised -> gnt=3'b001 persists for 50+ cycles and preempt stays 0.
- Reset mid-ownership: owner 2 with hold_cnt=3, rst=1 for one cycle with req=3'b111 -> gnt=0 the cycle after. Re-grant to 3'b100 follows with hold_cnt restarted from 0 (preemption only after another full MAX_HOLD).
- Starvation guard (macro defined): STARVE_LIMIT=16, MAX_HOLD=4, req=3'b111 constant -> requester 0 granted within 16 + 4 + 1 cycles. With the macro undefined, requester 0 is never granted while bits 2 and 1 stay high.
